// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory hierarchy (RAM8 and the levels above).
// Contents:
//   WORD_WIDTH, RAM8_ADDR_WIDTH, RAM8_DEPTH  - architectural sizes
//   word_t, ram8_addr_t                      - word and RAM8 address types
//   mux8_slot()                              - library 8-way select ordering,
//                                              shared by the 8:1 mux and the 1:8 demux
package hack_pkg;

  localparam int WORD_WIDTH      = 16;
  localparam int RAM8_ADDR_WIDTH = 3;
  localparam int RAM8_DEPTH      = 1 << RAM8_ADDR_WIDTH;

  typedef logic [WORD_WIDTH-1:0]      word_t;
  typedef logic [RAM8_ADDR_WIDTH-1:0] ram8_addr_t;

  // The mux library resolves sel[0] in its first (widest) stage and sel[2]
  // in its last, so input slot numbers are the select bits reversed.
  // The mapping is its own inverse, so it also converts slot -> address.
  function automatic ram8_addr_t mux8_slot(input ram8_addr_t sel);
    return {sel[0], sel[1], sel[2]};
  endfunction

endpackage

// File: rtl/demux_1x8.sv
// 1:8 single-bit demultiplexer, sibling of mux_8x1_16bits.
// Ports:
//   in_bit : bit to route
//   sel_in : 3-bit select, same slot ordering as the 8:1 mux
//   out    : eight outputs; only the selected slot may be high
module demux_1x8
  import hack_pkg::*;
(
  input  logic                  in_bit,
  input  ram8_addr_t            sel_in,
  output logic [RAM8_DEPTH-1:0] out
);

  always_comb begin
    // NOTE: default every output before the conditional so no latch is inferred.
    out = '0;
    // Gating on in_bit first keeps an unknown select from raising any
    // output while nothing is being routed.
    if (in_bit) begin
      out[mux8_slot(sel_in)] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_8x1_16bits.sv
// 8:1 16-bit multiplexer from the mux library.
// Ports:
//   a_in..h_in : word inputs, slots 0..7 in library order
//   sel_in     : 3-bit select, decoded through mux8_slot()
//   out        : selected word
module mux_8x1_16bits
  import hack_pkg::*;
(
  input  word_t      a_in,
  input  word_t      b_in,
  input  word_t      c_in,
  input  word_t      d_in,
  input  word_t      e_in,
  input  word_t      f_in,
  input  word_t      g_in,
  input  word_t      h_in,
  input  ram8_addr_t sel_in,
  output word_t      out
);

  word_t slots [RAM8_DEPTH];

  assign slots[0] = a_in;
  assign slots[1] = b_in;
  assign slots[2] = c_in;
  assign slots[3] = d_in;
  assign slots[4] = e_in;
  assign slots[5] = f_in;
  assign slots[6] = g_in;
  assign slots[7] = h_in;

  assign out = slots[mux8_slot(sel_in)];

endmodule

// File: rtl/register_16bits.sv
// 16-bit register with load enable and asynchronous active-low clear.
// Ports:
//   clk_in   : clock, captures on rising edge
//   rst_n_in : async active-low reset, clears to 0
//   load_in  : capture data_in on the next rising edge
//   data_in  : word to store
//   data_out : stored word
module register_16bits
  import hack_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  load_in,
  input  word_t data_in,
  output word_t data_out
);

  word_t data_d;
  word_t data_q;

  always_comb begin
    data_d = load_in ? data_in : data_q;
  end

  // NOTE: the storage cells carry a reset because the RAM must read 0 at
  // every address while reset is held, not just after a first write.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/ram8_16bits.sv
// RAM8: eight 16-bit words, combinational read, one-edge write.
// Ports:
//   clk_in     : clock, writes on rising edge
//   rst_n_in   : async active-low reset, clears all words
//   data_in    : write data
//   address_in : word select for read and write
//   load_in    : write enable
//   data_out   : contents of word address_in (no write-through)
module ram8_16bits
  import hack_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  word_t      data_in,
  input  ram8_addr_t address_in,
  input  logic       load_in,
  output word_t      data_out
);

  logic [RAM8_DEPTH-1:0] slot_load;
  word_t                 word_q  [RAM8_DEPTH];
  word_t                 mux_in  [RAM8_DEPTH];

  demux_1x8 u_write_decode (
    .in_bit (load_in),
    .sel_in (address_in),
    .out    (slot_load)
  );

  // Register k sits on library slot mux8_slot(k) for both the decoder and
  // the read mux, so the word read at address k is the one written there.
  for (genvar k = 0; k < RAM8_DEPTH; k++) begin : g_word
    register_16bits u_word (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .load_in  (slot_load[mux8_slot(ram8_addr_t'(k))]),
      .data_in  (data_in),
      .data_out (word_q[k])
    );
    assign mux_in[mux8_slot(ram8_addr_t'(k))] = word_q[k];
  end

  mux_8x1_16bits u_read_mux (
    .a_in   (mux_in[0]),
    .b_in   (mux_in[1]),
    .c_in   (mux_in[2]),
    .d_in   (mux_in[3]),
    .e_in   (mux_in[4]),
    .f_in   (mux_in[5]),
    .g_in   (mux_in[6]),
    .h_in   (mux_in[7]),
    .sel_in (address_in),
    .out    (data_out)
  );

endmodule

// File: tb/tb_ram8_16bits.sv
`timescale 1ns/100ps
module tb_ram8_16bits;

  logic        clk_in;
  logic        rst_n_in;
  logic [15:0] data_in;
  logic [2:0]  address_in;
  logic        load_in;
  logic [15:0] data_out;

  int checks   = 0;
  int failures = 0;

  ram8_16bits dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .data_in    (data_in),
    .address_in (address_in),
    .load_in    (load_in),
    .data_out   (data_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        load;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_pre;   // data_out before the edge
    logic [15:0] exp_post;  // data_out after the edge
  } vec_t;

  vec_t vecs [$];
  logic [15:0] model [8];

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, actual, expected);
    end
  endtask

  // Advance to 1ns after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all(input string name, input logic [15:0] expected [8]);
    for (int a = 0; a < 8; a++) begin
      address_in = 3'(a);
      #0.2;
      check($sformatf("%s addr%0d", name, a), data_out, expected[a]);
    end
  endtask

  initial begin
    rst_n_in   = 1'b0;
    load_in    = 1'b1;
    data_in    = 16'hFFFF;
    address_in = 3'd0;
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;

    // Reset value, during reset with writes attempted on every address.
    #1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      check_all("reset_during", model);
    end
    load_in  = 1'b0;
    rst_n_in = 1'b1;
    next_cycle();
    check_all("reset_after", model);

    // Directed table: address mapping, write timing, back-to-back writes.
    for (int k = 0; k < 8; k++)
      vecs.push_back('{1'b1, 3'(k), 16'h1000 + 16'(k), 16'h0000, 16'h1000 + 16'(k)});
    for (int k = 0; k < 8; k++)
      vecs.push_back('{1'b0, 3'(k), 16'hFFFF, 16'h1000 + 16'(k), 16'h1000 + 16'(k)});
    vecs.push_back('{1'b1, 3'd5, 16'h00AA, 16'h1005, 16'h00AA});
    vecs.push_back('{1'b1, 3'd5, 16'h5555, 16'h00AA, 16'h5555});
    vecs.push_back('{1'b1, 3'd4, 16'h1111, 16'h1004, 16'h1111});
    vecs.push_back('{1'b1, 3'd4, 16'h2222, 16'h1111, 16'h2222});
    vecs.push_back('{1'b1, 3'd4, 16'h3333, 16'h2222, 16'h3333});
    vecs.push_back('{1'b0, 3'd4, 16'h0000, 16'h3333, 16'h3333});

    foreach (vecs[i]) begin
      load_in    = vecs[i].load;
      address_in = vecs[i].addr;
      data_in    = vecs[i].data;
      #1;
      check($sformatf("vec%0d pre", i), data_out, vecs[i].exp_pre);
      next_cycle();
      check($sformatf("vec%0d post", i), data_out, vecs[i].exp_post);
    end
    for (int a = 0; a < 8; a++) model[a] = 16'h1000 + 16'(a);
    model[5] = 16'h5555;
    model[4] = 16'h3333;
    load_in  = 1'b0;
    check_all("table_final", model);

    // Load gating: data changes on address 3 with load low.
    address_in = 3'd3;
    data_in    = 16'hDEAD;
    load_in    = 1'b0;
    for (int c = 0; c < 10; c++) next_cycle();
    check("gate_addr3", data_out, model[3]);
    address_in = 3'd2;
    data_in    = 16'hBEEF;
    load_in    = 1'b1;
    next_cycle();
    load_in  = 1'b0;
    model[2] = 16'hBEEF;
    check_all("gate_beef", model);

    // Unknown address with load low leaves storage intact.
    address_in = 3'bxxx;
    data_in    = 16'h0BAD;
    for (int c = 0; c < 3; c++) next_cycle();
    check_all("x_addr", model);

    // Mid-operation reset: fill with A5A5, short low pulse between edges.
    data_in = 16'hA5A5;
    load_in = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address_in = 3'(a);
      next_cycle();
      model[a] = 16'hA5A5;
    end
    load_in = 1'b0;
    check_all("filled", model);
    next_cycle();
    rst_n_in = 1'b0;
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;
    check_all("midreset_low", model);
    rst_n_in = 1'b1;
    #0.5;
    check_all("midreset_released", model);
    address_in = 3'd7;
    data_in    = 16'h0001;
    load_in    = 1'b1;
    next_cycle();
    load_in  = 1'b0;
    model[7] = 16'h0001;
    check_all("after_reset_write", model);

    // Random sequence against the reference array.
    for (int c = 0; c < 1000; c++) begin
      address_in = 3'($urandom_range(0, 7));
      load_in    = 1'($urandom_range(0, 1));
      data_in    = 16'($urandom);
      #1;
      check($sformatf("rand%0d", c), data_out, model[address_in]);
      if (load_in) model[address_in] = data_in;
      next_cycle();
    end
    load_in = 1'b0;
    check_all("rand_final", model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
